// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-side blocks (ROM arbiter and friends).
package cpu_mem_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 8;

    // Byte returned for unimplemented ROM space; decodes as a harmless instruction.
    localparam logic [7:0] NOP_OPCODE = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

endpackage

// File: rtl/rom_arb_priority.sv
// Grant selection between fetch and data-read ports, with a starvation guard for fetch.
module rom_arb_priority
    import cpu_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    if_req,
    input  logic    dr_req,
    input  logic    arbitrate,
    output req_id_t grant_id,
    output logic    grant_valid
);

    localparam int CNT_W = 4;

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        starved     = (starve_cnt == CNT_W'(STARVE_LIMIT));
        grant_valid = if_req | dr_req;
        grant_id    = (dr_req && !(if_req && starved)) ? REQ_DATA : REQ_FETCH;
    end

    // Counts data grants taken while fetch was waiting; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (arbitrate && grant_valid) begin
            if (grant_id == REQ_DATA && if_req) begin
                if (!starved) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares the asynchronous-read program ROM between instruction fetch and execute-stage data reads.
module rom_access_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int WAIT_STATES  = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int ROM_DEPTH    = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dr_req,
    input  logic [ADDR_W-1:0] dr_addr,
    output logic              dr_ack,
    output logic [DATA_W-1:0] dr_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              addr_err,
    output logic              busy,
    output logic              grant_id
);

    localparam int WAIT_W = 3;

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    req_id_t           grant_sel;
    logic              grant_valid;
    logic              out_of_range;
    logic [DATA_W-1:0] rd_byte;

    rom_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_priority (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .dr_req     (dr_req),
        .arbitrate  (state == IDLE),
        .grant_id   (grant_sel),
        .grant_valid(grant_valid)
    );

    // rom_addr holds the address latched at grant, so range check and data belong to the same access.
    assign out_of_range = (33'(rom_addr) >= 33'(ROM_DEPTH));
    assign rd_byte      = out_of_range ? DATA_W'(NOP_OPCODE) : rom_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rom_addr <= '0;
            if_rdata <= '0;
            dr_rdata <= '0;
            if_ack   <= 1'b0;
            dr_ack   <= 1'b0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
            grant_id <= REQ_FETCH;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        rom_addr <= (grant_sel == REQ_DATA) ? dr_addr : if_addr;
                        grant_id <= grant_sel;
                        wait_cnt <= WAIT_W'(WAIT_STATES);
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end else begin
                        if (grant_id == REQ_DATA) begin
                            dr_rdata <= rd_byte;
                            dr_ack   <= 1'b1;
                        end else begin
                            if_rdata <= rd_byte;
                            if_ack   <= 1'b1;
                        end
                        addr_err <= out_of_range;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    // Requests are ignored here: the acked requester still shows req this cycle.
                    if_ack   <= 1'b0;
                    dr_ack   <= 1'b0;
                    addr_err <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench: table vectors, corner-case sequences and a randomized run against a schedule model.
module tb_rom_access_arbiter;

    localparam int NI          = 2;
    localparam int RAND_CYCLES = 3000;

    logic        clk;
    logic        rst_n;
    logic        if_req   [NI];
    logic [15:0] if_addr  [NI];
    logic        if_ack   [NI];
    logic [7:0]  if_rdata [NI];
    logic        dr_req   [NI];
    logic [15:0] dr_addr  [NI];
    logic        dr_ack   [NI];
    logic [7:0]  dr_rdata [NI];
    logic [15:0] rom_addr [NI];
    logic [7:0]  rom_data [NI];
    logic        addr_err [NI];
    logic        busy     [NI];
    logic        grant_id [NI];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_if [NI];
    logic [7:0] exp_dr [NI];

    typedef struct {
        int          inst;
        int          port;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    // Instance 0: no wait states, full 64 KB, starvation limit 2.
    // Instance 1: three wait states, 256-byte ROM, starvation limit 4.
    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 65536 : 256;
    endfunction

    function automatic int limit_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic logic [7:0] rom_img(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h01;
            16'h0001: return 8'h8C;
            16'h0002: return 8'h16;
            16'h0003: return 8'h48;
            16'h0004: return 8'hFC;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    assign rom_data[0] = rom_img(rom_addr[0]);
    assign rom_data[1] = rom_img(rom_addr[1]);

    rom_access_arbiter #(
        .WAIT_STATES (0),
        .STARVE_LIMIT(2)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
        .dr_req(dr_req[0]), .dr_addr(dr_addr[0]), .dr_ack(dr_ack[0]), .dr_rdata(dr_rdata[0]),
        .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
        .addr_err(addr_err[0]), .busy(busy[0]), .grant_id(grant_id[0])
    );

    rom_access_arbiter #(
        .WAIT_STATES (3),
        .STARVE_LIMIT(4),
        .ROM_DEPTH   (256)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
        .dr_req(dr_req[1]), .dr_addr(dr_addr[1]), .dr_ack(dr_ack[1]), .dr_rdata(dr_rdata[1]),
        .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
        .addr_err(addr_err[1]), .busy(busy[1]), .grant_id(grant_id[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int port, input logic val, input logic [15:0] a);
        if (port == 0) begin
            if_req[k]  = val;
            if_addr[k] = a;
        end else begin
            dr_req[k]  = val;
            dr_addr[k] = a;
        end
    endtask

    function automatic logic ack_of(input int k, input int port);
        return (port == 0) ? if_ack[k] : dr_ack[k];
    endfunction

    function automatic logic [7:0] rdata_of(input int k, input int port);
        return (port == 0) ? if_rdata[k] : dr_rdata[k];
    endfunction

    function automatic logic [7:0] exp_of(input int k, input int port);
        return (port == 0) ? exp_if[k] : exp_dr[k];
    endfunction

    // Call right after the cycle in which the request went up; returns at the negedge of the ack cycle.
    task automatic wait_ack(input int k, input int max_cyc, output int lat, output logic got);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i <= max_cyc; i++) begin
            @(negedge clk);
            if (if_ack[k] || dr_ack[k]) begin
                lat = i;
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic check_reset(input int k, input string tag);
        check($sformatf("%s_flags%0d", tag, k),
              {27'd0, if_ack[k], dr_ack[k], addr_err[k], busy[k], grant_id[k]}, 32'd0);
        check($sformatf("%s_rdata%0d", tag, k), {16'd0, if_rdata[k], dr_rdata[k]}, 32'd0);
        check($sformatf("%s_rom_addr%0d", tag, k), {16'd0, rom_addr[k]}, 32'd0);
    endtask

    task automatic clear_exp();
        for (int k = 0; k < NI; k++) begin
            exp_if[k] = 8'h00;
            exp_dr[k] = 8'h00;
        end
    endtask

    task automatic drop_all();
        for (int k = 0; k < NI; k++) begin
            set_req(k, 0, 1'b0, 16'h0000);
            set_req(k, 1, 1'b0, 16'h0000);
        end
    endtask

    task automatic run_vector(input int i);
        int   k;
        int   p;
        int   lat;
        logic got;
        k = vecs[i].inst;
        p = vecs[i].port;
        step();
        set_req(k, p, 1'b1, vecs[i].addr);
        wait_ack(k, 20, lat, got);
        check($sformatf("vec%0d_got", i), got, 1);
        check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        check($sformatf("vec%0d_ack", i), ack_of(k, p), 1);
        check($sformatf("vec%0d_other_ack", i), ack_of(k, 1 - p), 0);
        check($sformatf("vec%0d_rdata", i), rdata_of(k, p), vecs[i].data);
        check($sformatf("vec%0d_err", i), addr_err[k], vecs[i].err);
        check($sformatf("vec%0d_other_rdata", i), rdata_of(k, 1 - p), exp_of(k, 1 - p));
        check($sformatf("vec%0d_grant", i), grant_id[k], p);
        if (p == 0) exp_if[k] = vecs[i].data;
        else        exp_dr[k] = vecs[i].data;
        step();
        set_req(k, p, 1'b0, 16'h0000);
    endtask

    // Random-phase requester and model state.
    logic        r_req    [NI][2];
    logic [15:0] r_addr   [NI][2];
    logic        r_acked  [NI][2];
    int          m_free_at[NI];
    int          m_arb_at [NI];
    int          m_ack_at [NI];
    int          m_who    [NI];
    logic [15:0] m_addr   [NI];
    int          m_starve [NI];

    function automatic logic [15:0] rand_addr(input int k);
        return (k == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 511));
    endfunction

    initial begin
        int   lat;
        int   n_ack;
        logic got;
        logic fetch_turn;

        vecs[0] = '{0, 0, 16'h0000, 8'h01, 1'b0, 2};
        vecs[1] = '{1, 1, 16'h0004, 8'hFC, 1'b0, 5};
        vecs[2] = '{1, 1, 16'h0100, 8'h00, 1'b1, 5};
        vecs[3] = '{1, 1, 16'h0003, 8'h48, 1'b0, 5};
        vecs[4] = '{0, 1, 16'hFFFF, 8'h5A, 1'b0, 2};
        vecs[5] = '{0, 0, 16'h0002, 8'h16, 1'b0, 2};
        vecs[6] = '{1, 0, 16'h00FF, 8'hA5, 1'b0, 5};
        vecs[7] = '{0, 1, 16'h0100, 8'h5B, 1'b0, 2};

        rst_n = 1'b0;
        drop_all();
        clear_exp();
        @(negedge clk);
        check_reset(0, "reset");
        check_reset(1, "reset");
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vector(i);
        end

        // Fetch of 0x0000 with no wait states: rom_addr and busy through ACCESS and RESP.
        step();
        set_req(0, 0, 1'b1, 16'h0000);
        @(negedge clk);
        check("seq_rom_c0_busy", busy[0], 0);
        step();
        @(negedge clk);
        check("seq_rom_c1_addr", rom_addr[0], 16'h0000);
        check("seq_rom_c1_busy", busy[0], 1);
        check("seq_rom_c1_grant", grant_id[0], 0);
        check("seq_rom_c1_ack", if_ack[0], 0);
        step();
        @(negedge clk);
        check("seq_rom_c2_addr", rom_addr[0], 16'h0000);
        check("seq_rom_c2_ack", if_ack[0], 1);
        check("seq_rom_c2_rdata", if_rdata[0], 8'h01);
        check("seq_rom_c2_busy", busy[0], 1);
        exp_if[0] = 8'h01;
        step();
        set_req(0, 0, 1'b0, 16'h0000);
        @(negedge clk);
        check("seq_rom_c3_busy", busy[0], 0);
        check("seq_rom_c3_ack", if_ack[0], 0);

        // Address moves after the grant edge; the latched address must win.
        step();
        set_req(0, 0, 1'b1, 16'h0000);
        step();
        set_req(0, 0, 1'b1, 16'h0003);
        wait_ack(0, 20, lat, got);
        check("seq_addr_got", got, 1);
        check("seq_addr_lat", lat, 1);
        check("seq_addr_rdata", if_rdata[0], 8'h01);
        exp_if[0] = 8'h01;
        step();
        set_req(0, 0, 1'b0, 16'h0000);

        // Both ports held: four data grants, then one fetch, repeating.
        step();
        set_req(1, 0, 1'b1, 16'h0002);
        set_req(1, 1, 1'b1, 16'h0003);
        n_ack = 0;
        for (int i = 0; i < 200 && n_ack < 10; i++) begin
            @(negedge clk);
            if (if_ack[1] || dr_ack[1]) begin
                fetch_turn = ((n_ack % 5) == 4);
                check($sformatf("starve%0d_acks", n_ack), {if_ack[1], dr_ack[1]},
                      fetch_turn ? 2'b10 : 2'b01);
                check($sformatf("starve%0d_rdata", n_ack),
                      fetch_turn ? if_rdata[1] : dr_rdata[1], fetch_turn ? 8'h16 : 8'h48);
                n_ack++;
            end
            step();
        end
        check("starve_ack_count", n_ack, 10);
        set_req(1, 0, 1'b0, 16'h0000);
        set_req(1, 1, 1'b0, 16'h0000);
        exp_if[1] = 8'h16;
        exp_dr[1] = 8'h48;

        // Reset in the middle of an access: outputs clear immediately, no ack, re-issue works.
        step();
        set_req(1, 0, 1'b1, 16'h0000);
        step();
        @(negedge clk);
        check("rst_mid_busy", busy[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(0, "rst_mid");
        check_reset(1, "rst_mid");
        step();
        @(negedge clk);
        check("rst_hold_acks", {if_ack[1], dr_ack[1]}, 2'b00);
        check("rst_hold_busy", busy[1], 0);
        step();
        rst_n = 1'b1;
        clear_exp();
        wait_ack(1, 20, lat, got);
        check("rst_reissue_got", got, 1);
        check("rst_reissue_lat", lat, 5);
        check("rst_reissue_ack", if_ack[1], 1);
        check("rst_reissue_rdata", if_rdata[1], 8'h01);
        check("rst_reissue_other", dr_rdata[1], 8'h00);
        exp_if[1] = 8'h01;
        step();
        set_req(1, 0, 1'b0, 16'h0000);

        // Randomized traffic on both instances against a grant-schedule model.
        step();
        drop_all();
        rst_n = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        clear_exp();
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 2; p++) begin
                r_req[k][p]   = 1'b0;
                r_addr[k][p]  = 16'h0000;
                r_acked[k][p] = 1'b0;
            end
            m_free_at[k] = 0;
            m_arb_at[k]  = -1;
            m_ack_at[k]  = -1;
            m_who[k]     = 0;
            m_addr[k]    = 16'h0000;
            m_starve[k]  = 0;
        end

        for (int t = 0; t < RAND_CYCLES; t++) begin
            for (int k = 0; k < NI; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (r_req[k][p] && r_acked[k][p]) begin
                        r_acked[k][p] = 1'b0;
                        if ($urandom_range(0, 1) == 1) r_addr[k][p] = rand_addr(k);
                        else                            r_req[k][p]  = 1'b0;
                    end else if (!r_req[k][p] && $urandom_range(0, 2) == 0) begin
                        r_req[k][p]  = 1'b1;
                        r_addr[k][p] = rand_addr(k);
                    end
                    set_req(k, p, r_req[k][p], r_addr[k][p]);
                end
                if (t >= m_free_at[k] && (r_req[k][0] || r_req[k][1])) begin
                    m_who[k]     = (r_req[k][1] && !(r_req[k][0] && m_starve[k] == limit_of(k))) ? 1 : 0;
                    m_addr[k]    = r_addr[k][m_who[k]];
                    m_arb_at[k]  = t;
                    m_ack_at[k]  = t + ws_of(k) + 2;
                    m_free_at[k] = t + ws_of(k) + 3;
                    if (m_who[k] == 1 && r_req[k][0])
                        m_starve[k] = (m_starve[k] < limit_of(k)) ? m_starve[k] + 1 : m_starve[k];
                    else
                        m_starve[k] = 0;
                end
            end
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                logic ack_now;
                logic oor;
                ack_now = (t == m_ack_at[k]);
                oor     = (int'(m_addr[k]) >= depth_of(k));
                if (ack_now) begin
                    if (m_who[k] == 1) exp_dr[k] = oor ? 8'h00 : rom_img(m_addr[k]);
                    else               exp_if[k] = oor ? 8'h00 : rom_img(m_addr[k]);
                    r_acked[k][m_who[k]] = 1'b1;
                end
                check($sformatf("rand%0d_t%0d_acks", k, t), {if_ack[k], dr_ack[k]},
                      {ack_now && m_who[k] == 0, ack_now && m_who[k] == 1});
                check($sformatf("rand%0d_t%0d_err", k, t), addr_err[k], ack_now && oor);
                check($sformatf("rand%0d_t%0d_if_rdata", k, t), if_rdata[k], exp_if[k]);
                check($sformatf("rand%0d_t%0d_dr_rdata", k, t), dr_rdata[k], exp_dr[k]);
                check($sformatf("rand%0d_t%0d_busy", k, t), busy[k],
                      (t > m_arb_at[k]) && (t <= m_ack_at[k]));
                if ((t > m_arb_at[k]) && (t <= m_ack_at[k]))
                    check($sformatf("rand%0d_t%0d_grant", k, t), grant_id[k], m_who[k]);
            end
            step();
        end
        drop_all();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
